// File: rtl/iter_sqacc_engine.sv
// Iterative square-accumulate engine: NCH lanes each run acc = (acc + comp)^2 for ITERS cycles,
// gated by a parity-history register. Optional abort input is enabled with ITER_SQACC_ABORT_EN.
module iter_sqacc_engine #(
  parameter int WIDTH = 32,
  parameter int NCH   = 2,
  parameter int ITERS = 10,
  parameter int HIST  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_cond,
  input  logic [NCH*WIDTH-1:0] in_comp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 out_gated,
`ifdef ITER_SQACC_ABORT_EN
  input  logic                 abort,
`endif
  output logic [1:0]           dbg_state,  // 0 = IDLE, 1 = RUN, 2 = DONE
  output logic [HIST-1:0]      dbg_hist
);

  // Handshakes: a transfer happens on a posedge where valid & ready are both high; a
  // producer holds valid and its payload until that edge, and ready never depends on valid.

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [HIST-1:0]  hist, hist_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc [NCH];
  logic [WIDTH-1:0] comp [NCH];
  logic [WIDTH-1:0] sq [NCH];
  logic             gate, par, last_iter, abort_run;

`ifdef ITER_SQACC_ABORT_EN
  assign abort_run = abort;
`else
  assign abort_run = 1'b0;
`endif

  assign gate      = hist[HIST-1] | in_cond;
  assign par       = (^hist) ^ in_cond;
  // Shifting left and OR-ing in the new bit also covers HIST == 1.
  assign hist_next = (hist << 1) | HIST'(par);
  assign last_iter = (cnt == CW'(ITERS - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;
  assign dbg_hist  = hist;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      sq[k] = (acc[k] + comp[k]) * (acc[k] + comp[k]);
    end
  end

  // acc is itself a register, so the result bus carries no arithmetic path.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NCH; k++) begin
      out_data[k*WIDTH +: WIDTH] = acc[k];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = gate ? RUN : DONE;
      RUN: begin
        if (abort_run)      state_next = IDLE;
        else if (last_iter) state_next = DONE;
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      cnt       <= '0;
      out_gated <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        acc[k]  <= '0;
        comp[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hist      <= hist_next;
            cnt       <= '0;
            out_gated <= gate;
            for (int k = 0; k < NCH; k++) begin
              acc[k]  <= '0;
              comp[k] <= in_comp[k*WIDTH +: WIDTH];
            end
          end
        end
        RUN: begin
          if (!abort_run) begin
            cnt <= cnt + CW'(1);
            for (int k = 0; k < NCH; k++) acc[k] <= sq[k];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_sqacc_engine.sv
// Bench for iter_sqacc_engine: directed scenarios then random transactions, compared against a
// behavioural model of the gating history and the per-lane square-accumulate recurrence.
module tb_iter_sqacc_engine;

  localparam int W  = 8;
  localparam int NC = 2;
  localparam int IT = 3;
  localparam int HS = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_cond;
  logic [NC*W-1:0]   in_comp;
  logic              out_valid;
  logic              out_ready;
  logic [NC*W-1:0]   out_data;
  logic              out_gated;
  logic [1:0]        dbg_state;
  logic [HS-1:0]     dbg_hist;
`ifdef ITER_SQACC_ABORT_EN
  logic              abort;
`endif

  int checks   = 0;
  int failures = 0;
  bit par_q[$];

  iter_sqacc_engine #(.WIDTH(W), .NCH(NC), .ITERS(IT), .HIST(HS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond), .in_comp(in_comp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_gated(out_gated),
`ifdef ITER_SQACC_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(dbg_state), .dbg_hist(dbg_hist)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // History as seen by the engine: bit i is the parity pushed i accepts ago.
  function automatic logic [HS-1:0] model_hist();
    logic [HS-1:0] h = '0;
    for (int i = 0; i < HS; i++)
      if (i < par_q.size()) h[i] = par_q[par_q.size()-1-i];
    return h;
  endfunction

  function automatic logic [W-1:0] lane_model(input logic [W-1:0] c);
    logic [W-1:0] a = '0;
    repeat (IT) a = (a + c) * (a + c);
    return a;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
`ifdef ITER_SQACC_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    par_q.delete();
  endtask

  task automatic send(input string tag, input logic cond, input logic [NC*W-1:0] comp,
                      input int hold);
    logic [HS-1:0]   h;
    logic            gate;
    logic [NC*W-1:0] exp_data;
    logic [NC*W-1:0] first;
    int              lat;
    h    = model_hist();
    gate = h[HS-1] | cond;
    par_q.push_back((^h) ^ cond);
    exp_data = '0;
    if (gate)
      for (int k = 0; k < NC; k++) exp_data[k*W +: W] = lane_model(comp[k*W +: W]);
    check({tag, ".in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; in_cond = cond; in_comp = comp;
    tick();
    in_valid = 1'b0; in_comp = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, lat, gate ? IT + 1 : 1);
    check({tag, ".data"}, out_data, exp_data);
    check({tag, ".gated"}, out_gated, gate);
    check({tag, ".hist"}, dbg_hist, model_hist());
    first = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_cond = 1'($urandom);
      tick();
      check({tag, ".hold_valid"}, out_valid, 1'b1);
      check({tag, ".hold_data"}, out_data, first);
      check({tag, ".hold_ready"}, in_ready, 1'b0);
      check({tag, ".hold_hist"}, dbg_hist, model_hist());
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".released"}, out_valid, 1'b0);
  endtask

  initial begin
    in_cond = 1'b0; in_comp = '0;
    do_reset();
    // Reset state
    check("reset.in_ready", in_ready, 1'b1);
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.out_data", out_data, '0);
    check("reset.out_gated", out_gated, 1'b0);
    check("reset.hist", dbg_hist, '0);
    check("reset.state", dbg_state, 2'd0);

    // T1: lane0 comp=1 -> 1,4,25; lane1 comp=0 stays 0
    send("t1", 1'b1, {8'd0, 8'd1}, 0);
    check("t1.const", out_data, {8'd0, 8'd25});

    // T2: ungated, forced zero, 1-cycle latency
    do_reset();
    send("t2", 1'b0, {8'd7, 8'd7}, 0);

    // T3: wrap modulo 256 (0x10 squares to 0), and 3 -> 9,144,105
    do_reset();
    send("t3a", 1'b1, {8'h10, 8'd3}, 0);
    check("t3a.const", out_data, {8'd0, 8'd105});

    // T4: cond 1,0,0 -> hist 01,11,10, gates 1,0,1
    do_reset();
    send("t4a", 1'b1, {8'd2, 8'd5}, 0);
    check("t4a.hist_const", dbg_hist, 2'b01);
    check("t4a.gate_const", out_gated, 1'b1);
    send("t4b", 1'b0, {8'd2, 8'd5}, 0);
    check("t4b.hist_const", dbg_hist, 2'b11);
    check("t4b.gate_const", out_gated, 1'b0);
    send("t4c", 1'b0, {8'd2, 8'd5}, 0);
    check("t4c.hist_const", dbg_hist, 2'b10);
    check("t4c.gate_const", out_gated, 1'b1);

    // T5: consumer stalls 5 cycles while a new request waits
    send("t5", 1'b1, {8'd9, 8'd4}, 5);

    // T6: reset at RUN cnt=1 discards the result and clears history
    in_valid = 1'b1; in_cond = 1'b1; in_comp = {8'd1, 8'd1};
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    par_q.delete();
    check("t6.in_ready", in_ready, 1'b1);
    check("t6.out_valid", out_valid, 1'b0);
    check("t6.hist", dbg_hist, '0);
    check("t6.out_data", out_data, '0);
    send("t6.next", 1'b1, {8'd1, 8'd2}, 0);

`ifdef ITER_SQACC_ABORT_EN
    begin
      logic [HS-1:0] h;
      h = model_hist();
      par_q.push_back((^h) ^ 1'b1);
      in_valid = 1'b1; in_cond = 1'b1; in_comp = {8'd3, 8'd3};
      tick();
      in_valid = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort.in_ready", in_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
        tick();
        check("abort.no_valid", out_valid, 1'b0);
      end
      check("abort.hist", dbg_hist, model_hist());
      send("abort.next", 1'b1, {8'd6, 8'd1}, 0);
    end
`endif

    // Random transactions
    for (int n = 0; n < 30; n++) begin
      send("rand", 1'($urandom), 16'($urandom), $urandom_range(0, 2));
      repeat ($urandom_range(0, 1)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
